// File: rtl/tmboc_epl_corr.sv
`default_nettype none
// ============================================================================
//  Module      : tmboc_epl_corr
//  Description : Early/prompt/late complex integrate-and-dump correlator for
//                the B1 pilot TMBOC channel, valid/ready dump interface.
//  Revision    : 1.0  initial release
// ============================================================================
module tmboc_epl_corr #(
  parameter int IN_WIDTH  = 16,
  parameter int ACC_WIDTH = 32,
  parameter int DUMP_CNT  = 1
) (
  input  logic                        rx_clk,
  input  logic                        rx_rst_n,
  input  logic                        rx_en,
  input  logic signed [IN_WIDTH-1:0]  rx_src_real,
  input  logic signed [IN_WIDTH-1:0]  rx_src_imag,
  input  logic                        rx_loc_tmbocE,
  input  logic                        rx_loc_tmbocP,
  input  logic                        rx_loc_tmbocL,
  input  logic                        rx_prn_sop,
  output logic signed [ACC_WIDTH-1:0] tx_ie,
  output logic signed [ACC_WIDTH-1:0] tx_qe,
  output logic signed [ACC_WIDTH-1:0] tx_ip,
  output logic signed [ACC_WIDTH-1:0] tx_qp,
  output logic signed [ACC_WIDTH-1:0] tx_il,
  output logic signed [ACC_WIDTH-1:0] tx_ql,
  output logic                        tx_valid,
  input  logic                        rx_ready,
  output logic                        tx_sat,
  output logic                        tx_lost
);

  localparam logic [0:0] c_IDLE  = 1'b0;
  localparam logic [0:0] c_ACCUM = 1'b1;

  localparam int c_CNT_W = (DUMP_CNT > 1) ? $clog2(DUMP_CNT) : 1;
  localparam logic [c_CNT_W-1:0] c_LAST = c_CNT_W'(DUMP_CNT - 1);

  localparam logic signed [IN_WIDTH-1:0]  c_IN_MIN  = {1'b1, {(IN_WIDTH-1){1'b0}}};
  localparam logic signed [IN_WIDTH-1:0]  c_IN_MAX  = {1'b0, {(IN_WIDTH-1){1'b1}}};
  localparam logic signed [ACC_WIDTH-1:0] c_ACC_MIN = {1'b1, {(ACC_WIDTH-1){1'b0}}};
  localparam logic signed [ACC_WIDTH-1:0] c_ACC_MAX = {1'b0, {(ACC_WIDTH-1){1'b1}}};

  logic signed [IN_WIDTH-1:0] r_s1_re;
  logic signed [IN_WIDTH-1:0] r_s1_im;
  logic [2:0]                 r_s1_rep;   // {L, P, E}
  logic                       r_s1_sop;
  logic                       r_s2_sop;

  logic [0:0]         r_state;
  logic [c_CNT_W-1:0] r_cnt;
  logic               r_sat;
  logic               r_valid;
  logic               r_tx_sat;
  logic               r_lost;

  logic w_start;
  logic w_run;
  logic w_dump;
  logic w_load;
  logic w_add;
  logic [5:0] w_clamp;
  logic signed [ACC_WIDTH-1:0] w_out [6];

  always_ff @(posedge rx_clk) begin
    if (!rx_rst_n) begin
      r_s1_re  <= '0;
      r_s1_im  <= '0;
      r_s1_rep <= '0;
      r_s1_sop <= 1'b0;
      r_s2_sop <= 1'b0;
    end else begin
      r_s1_re  <= rx_src_real;
      r_s1_im  <= rx_src_imag;
      r_s1_rep <= {rx_loc_tmbocL, rx_loc_tmbocP, rx_loc_tmbocE};
      r_s1_sop <= rx_prn_sop;
      r_s2_sop <= r_s1_sop;
    end
  end

  assign w_start = rx_en && (r_state == c_IDLE) && r_s2_sop;
  assign w_run   = rx_en && (r_state == c_ACCUM);
  assign w_dump  = w_run && r_s2_sop && (r_cnt == c_LAST);
  assign w_load  = w_start || w_dump;
  assign w_add   = w_run && !w_dump;

  // Lanes: 0=IE 1=QE 2=IP 3=QP 4=IL 5=QL
  for (genvar k = 0; k < 6; k++) begin : g_lane
    logic signed [IN_WIDTH-1:0]  w_x;
    logic                        w_rep;
    logic signed [IN_WIDTH-1:0]  w_neg;
    logic signed [ACC_WIDTH-1:0] w_prod_nxt;
    logic [ACC_WIDTH:0]          w_sum;
    logic signed [ACC_WIDTH-1:0] w_sat_val;
    logic signed [ACC_WIDTH-1:0] r_prod;
    logic signed [ACC_WIDTH-1:0] r_acc;
    logic signed [ACC_WIDTH-1:0] r_out;

    assign w_x        = (k % 2 == 0) ? r_s1_re : r_s1_im;
    assign w_rep      = r_s1_rep[k/2];
    assign w_neg      = (w_x == c_IN_MIN) ? c_IN_MAX : -w_x;
    assign w_prod_nxt = ACC_WIDTH'(w_rep ? w_x : w_neg);
    assign w_sum      = {r_acc[ACC_WIDTH-1], r_acc} + {r_prod[ACC_WIDTH-1], r_prod};
    assign w_clamp[k] = w_sum[ACC_WIDTH] ^ w_sum[ACC_WIDTH-1];
    assign w_sat_val  = w_sum[ACC_WIDTH] ? c_ACC_MIN : c_ACC_MAX;
    assign w_out[k]   = r_out;

    always_ff @(posedge rx_clk) begin
      if (!rx_rst_n) begin
        r_prod <= '0;
        r_acc  <= '0;
        r_out  <= '0;
      end else begin
        r_prod <= w_prod_nxt;
        // The sop sample opens a fresh sum rather than adding to the old one.
        if (w_load)
          r_acc <= r_prod;
        else if (w_add)
          r_acc <= w_clamp[k] ? w_sat_val : $signed(w_sum[ACC_WIDTH-1:0]);
        else
          r_acc <= '0;
        if (w_dump)
          r_out <= r_acc;
      end
    end
  end

  always_ff @(posedge rx_clk) begin
    if (!rx_rst_n) begin
      r_state  <= c_IDLE;
      r_cnt    <= '0;
      r_sat    <= 1'b0;
      r_valid  <= 1'b0;
      r_tx_sat <= 1'b0;
      r_lost   <= 1'b0;
    end else begin
      if (!rx_en) begin
        r_state <= c_IDLE;
        r_cnt   <= '0;
        r_sat   <= 1'b0;
      end else if (w_start) begin
        r_state <= c_ACCUM;
        r_cnt   <= '0;
        r_sat   <= 1'b0;
      end else if (w_dump) begin
        r_cnt   <= '0;
        r_sat   <= 1'b0;
      end else if (w_run) begin
        if (r_s2_sop)
          r_cnt <= r_cnt + c_CNT_W'(1);
        r_sat <= r_sat | (|w_clamp);
      end

      // A dump wins over an accept on the same edge so the new set stays valid.
      if (w_dump) begin
        r_valid  <= 1'b1;
        r_tx_sat <= r_sat;
        if (r_valid && !rx_ready)
          r_lost <= 1'b1;
      end else if (r_valid && rx_ready) begin
        r_valid <= 1'b0;
      end
    end
  end

  assign tx_ie    = w_out[0];
  assign tx_qe    = w_out[1];
  assign tx_ip    = w_out[2];
  assign tx_qp    = w_out[3];
  assign tx_il    = w_out[4];
  assign tx_ql    = w_out[5];
  assign tx_valid = r_valid;
  assign tx_sat   = r_tx_sat;
  assign tx_lost  = r_lost;

endmodule
`default_nettype wire

// File: tb/tb_tmboc_epl_corr.sv
`default_nettype none
// Directed bench for tmboc_epl_corr: three instances (default, 20-bit acc,
// four-period dump) share one stimulus stream; sel picks the one checked.
module tb_tmboc_epl_corr;

  logic rx_clk, rx_rst_n, rx_en, rx_ready;
  logic signed [15:0] rx_src_real, rx_src_imag;
  logic rx_loc_tmbocE, rx_loc_tmbocP, rx_loc_tmbocL, rx_prn_sop;

  logic signed [31:0] a_ie, a_qe, a_ip, a_qp, a_il, a_ql;
  logic signed [19:0] b_ie, b_qe, b_ip, b_qp, b_il, b_ql;
  logic signed [31:0] c_ie, c_qe, c_ip, c_qp, c_il, c_ql;
  logic a_valid, a_sat, a_lost, b_valid, b_sat, b_lost, c_valid, c_sat, c_lost;

  int total = 0;
  int bad   = 0;
  int sel   = 0;
  longint exp_v [6];
  logic exp_valid, exp_sat, exp_lost;

  tmboc_epl_corr #(.IN_WIDTH(16), .ACC_WIDTH(32), .DUMP_CNT(1)) u_a (
    .rx_clk(rx_clk), .rx_rst_n(rx_rst_n), .rx_en(rx_en),
    .rx_src_real(rx_src_real), .rx_src_imag(rx_src_imag),
    .rx_loc_tmbocE(rx_loc_tmbocE), .rx_loc_tmbocP(rx_loc_tmbocP), .rx_loc_tmbocL(rx_loc_tmbocL),
    .rx_prn_sop(rx_prn_sop),
    .tx_ie(a_ie), .tx_qe(a_qe), .tx_ip(a_ip), .tx_qp(a_qp), .tx_il(a_il), .tx_ql(a_ql),
    .tx_valid(a_valid), .rx_ready(rx_ready), .tx_sat(a_sat), .tx_lost(a_lost));

  tmboc_epl_corr #(.IN_WIDTH(16), .ACC_WIDTH(20), .DUMP_CNT(1)) u_b (
    .rx_clk(rx_clk), .rx_rst_n(rx_rst_n), .rx_en(rx_en),
    .rx_src_real(rx_src_real), .rx_src_imag(rx_src_imag),
    .rx_loc_tmbocE(rx_loc_tmbocE), .rx_loc_tmbocP(rx_loc_tmbocP), .rx_loc_tmbocL(rx_loc_tmbocL),
    .rx_prn_sop(rx_prn_sop),
    .tx_ie(b_ie), .tx_qe(b_qe), .tx_ip(b_ip), .tx_qp(b_qp), .tx_il(b_il), .tx_ql(b_ql),
    .tx_valid(b_valid), .rx_ready(rx_ready), .tx_sat(b_sat), .tx_lost(b_lost));

  tmboc_epl_corr #(.IN_WIDTH(16), .ACC_WIDTH(32), .DUMP_CNT(4)) u_c (
    .rx_clk(rx_clk), .rx_rst_n(rx_rst_n), .rx_en(rx_en),
    .rx_src_real(rx_src_real), .rx_src_imag(rx_src_imag),
    .rx_loc_tmbocE(rx_loc_tmbocE), .rx_loc_tmbocP(rx_loc_tmbocP), .rx_loc_tmbocL(rx_loc_tmbocL),
    .rx_prn_sop(rx_prn_sop),
    .tx_ie(c_ie), .tx_qe(c_qe), .tx_ip(c_ip), .tx_qp(c_qp), .tx_il(c_il), .tx_ql(c_ql),
    .tx_valid(c_valid), .rx_ready(rx_ready), .tx_sat(c_sat), .tx_lost(c_lost));

  initial rx_clk = 1'b0;
  always #5 rx_clk = ~rx_clk;

  function automatic longint ideal(input int x, input bit rep);
    if (rep) return longint'(x);
    if (x == -32768) return 64'sd32767;
    return -longint'(x);
  endfunction

  task automatic set_exp(input longint ie, qe, ip, qp, il, ql, input logic v, s, l);
    exp_v[0] = ie; exp_v[1] = qe; exp_v[2] = ip;
    exp_v[3] = qp; exp_v[4] = il; exp_v[5] = ql;
    exp_valid = v; exp_sat = s; exp_lost = l;
  endtask

  task automatic drive(input int re, input int im, input bit e, input bit p, input bit l, input bit sop);
    rx_src_real   = 16'(re);
    rx_src_imag   = 16'(im);
    rx_loc_tmbocE = e;
    rx_loc_tmbocP = p;
    rx_loc_tmbocL = l;
    rx_prn_sop    = sop;
    @(posedge rx_clk);
    #1;
  endtask

  task automatic check_set(input string tag);
    longint got [6];
    logic gv, gs, gl;
    string nm [6] = '{"ie", "qe", "ip", "qp", "il", "ql"};
    case (sel)
      0: begin got = '{a_ie, a_qe, a_ip, a_qp, a_il, a_ql}; gv = a_valid; gs = a_sat; gl = a_lost; end
      1: begin got = '{b_ie, b_qe, b_ip, b_qp, b_il, b_ql}; gv = b_valid; gs = b_sat; gl = b_lost; end
      default: begin got = '{c_ie, c_qe, c_ip, c_qp, c_il, c_ql}; gv = c_valid; gs = c_sat; gl = c_lost; end
    endcase
    for (int j = 0; j < 6; j++) begin
      total++;
      assert (got[j] === exp_v[j]) else begin
        bad++;
        $error("FAIL %s %s observed=%0d expected=%0d", tag, nm[j], got[j], exp_v[j]);
      end
    end
    total++;
    assert (gv === exp_valid) else begin
      bad++; $error("FAIL %s valid observed=%b expected=%b", tag, gv, exp_valid);
    end
    total++;
    assert (gs === exp_sat) else begin
      bad++; $error("FAIL %s sat observed=%b expected=%b", tag, gs, exp_sat);
    end
    total++;
    assert (gl === exp_lost) else begin
      bad++; $error("FAIL %s lost observed=%b expected=%b", tag, gl, exp_lost);
    end
  endtask

  // One PRN period with sop on its first sample; with chk set, the dump of
  // the previous period is checked once it becomes visible (third sample).
  task automatic period(input int len, input int re, input int im, input bit e, input bit p,
                        input bit l, input bit lalt, input bit chk, input string tag);
    logic gv;
    for (int i = 0; i < len; i++) begin
      drive(re, im, e, p, lalt ? ~i[0] : l, i == 0);
      if (chk && i == 2) check_set(tag);
      if (chk && i == 3 && rx_ready && exp_valid) begin
        gv = (sel == 0) ? a_valid : (sel == 1) ? b_valid : c_valid;
        total++;
        assert (gv === 1'b0) else begin
          bad++; $error("FAIL %s valid_drop observed=%b expected=0", tag, gv);
        end
      end
    end
  endtask

  task automatic do_reset();
    rx_rst_n = 1'b0;
    repeat (3) drive(0, 0, 0, 0, 0, 0);
    rx_rst_n = 1'b1;
    drive(0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    rx_rst_n = 1'b0; rx_en = 1'b0; rx_ready = 1'b1;
    rx_src_real = '0; rx_src_imag = '0;
    rx_loc_tmbocE = 1'b0; rx_loc_tmbocP = 1'b0; rx_loc_tmbocL = 1'b0; rx_prn_sop = 1'b0;

    // Reset state
    do_reset();
    sel = 0;
    set_exp(0, 0, 0, 0, 0, 0, 1'b0, 1'b0, 1'b0);
    check_set("reset");

    // All replicas +1
    rx_en = 1'b1;
    set_exp(800, -400, 800, -400, 800, -400, 1'b1, 1'b0, 1'b0);
    period(8, 100, -50, 1, 1, 1, 0, 0, "t1");
    period(8, 100, -50, 1, 1, 1, 0, 1, "t1_d1");
    period(8, 100, -50, 1, 1, 1, 0, 1, "t1_d2");

    // E=-1, L alternating
    period(8, 100, -50, 0, 1, 1, 1, 1, "t1_d3");
    set_exp(-800, 400, 800, -400, 0, 0, 1'b1, 1'b0, 1'b0);
    period(8, 100, -50, 0, 1, 1, 1, 1, "t2_d1");

    // 20-bit accumulator saturation over a 40-sample period
    period(40, 32767, 0, 1, 1, 1, 0, 1, "t2_d2");
    sel = 1;
    set_exp(524287, 0, 524287, 0, 524287, 0, 1'b1, 1'b1, 1'b0);
    period(8, 1, 0, 1, 1, 1, 0, 1, "t3_sat");
    set_exp(8, 0, 8, 0, 8, 0, 1'b1, 1'b0, 1'b0);
    period(8, 1, 0, 1, 1, 1, 0, 1, "t3_unsat");

    // Back-pressure across two dumps
    sel = 0;
    rx_ready = 1'b0;
    period(8, 10, 20, 1, 1, 1, 0, 0, "t4");
    set_exp(8, 0, 8, 0, 8, 0, 1'b1, 1'b0, 1'b0);
    check_set("t4_held");
    set_exp(80, 160, 80, 160, 80, 160, 1'b1, 1'b0, 1'b1);
    period(8, 0, 0, 1, 1, 1, 0, 1, "t4_overwrite");
    rx_ready = 1'b1;
    drive(0, 0, 1, 1, 1, 0);
    set_exp(80, 160, 80, 160, 80, 160, 1'b0, 1'b0, 1'b1);
    check_set("t4_accept");

    // Dump lands on the accepting edge
    do_reset();
    set_exp(0, 0, 0, 0, 0, 0, 1'b0, 1'b0, 1'b0);
    check_set("t5_reset");
    rx_ready = 1'b0;
    period(8, 5, 0, 1, 1, 1, 0, 0, "t5");
    period(8, 7, 0, 1, 1, 1, 0, 0, "t5");
    set_exp(40, 0, 40, 0, 40, 0, 1'b1, 1'b0, 1'b0);
    drive(9, 0, 1, 1, 1, 1);
    check_set("t5_first");
    drive(9, 0, 1, 1, 1, 0);
    check_set("t5_first_hold");
    rx_ready = 1'b1;
    drive(9, 0, 1, 1, 1, 0);
    set_exp(56, 0, 56, 0, 56, 0, 1'b1, 1'b0, 1'b0);
    check_set("t5_same_edge");
    drive(9, 0, 1, 1, 1, 0);
    set_exp(56, 0, 56, 0, 56, 0, 1'b0, 1'b0, 1'b0);
    check_set("t5_drop");

    // Most-negative sample negated
    period(8, -32768, -32768, 1, 0, 1, 0, 0, "t7");
    set_exp(8 * ideal(-32768, 1), 8 * ideal(-32768, 1), 8 * ideal(-32768, 0),
            8 * ideal(-32768, 0), 8 * ideal(-32768, 1), 8 * ideal(-32768, 1),
            1'b1, 1'b0, 1'b0);
    period(8, 0, 0, 1, 1, 1, 0, 1, "t7_minneg");

    // Four-period dump and mid-period reset
    do_reset();
    sel = 2;
    period(8, 1, 0, 1, 1, 1, 0, 0, "t6");
    set_exp(0, 0, 0, 0, 0, 0, 1'b0, 1'b0, 1'b0);
    for (int n = 0; n < 3; n++) period(8, 1, 0, 1, 1, 1, 0, 1, "t6_nodump");
    set_exp(32, 0, 32, 0, 32, 0, 1'b1, 1'b0, 1'b0);
    period(8, 1, 0, 1, 1, 1, 0, 1, "t6_dump");
    drive(1, 0, 1, 1, 1, 1);
    drive(1, 0, 1, 1, 1, 0);
    rx_rst_n = 1'b0;
    drive(1, 0, 1, 1, 1, 0);
    drive(1, 0, 1, 1, 1, 0);
    set_exp(0, 0, 0, 0, 0, 0, 1'b0, 1'b0, 1'b0);
    check_set("t6_midreset");
    rx_rst_n = 1'b1;
    drive(1, 0, 1, 1, 1, 0);
    period(8, 1, 0, 1, 1, 1, 0, 0, "t6b");
    for (int n = 0; n < 3; n++) period(8, 1, 0, 1, 1, 1, 0, 1, "t6b_nodump");
    set_exp(32, 0, 32, 0, 32, 0, 1'b1, 1'b0, 1'b0);
    period(8, 1, 0, 1, 1, 1, 0, 1, "t6b_dump");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
